// File: rtl/inst_split_pkg.sv
// Shared opcode constants, instruction-class encodings and extension helpers
// for the instruction split queue.
package inst_split_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    typedef enum logic [1:0] {
        ICLASS_R    = 2'b00,
        ICLASS_I    = 2'b01,
        ICLASS_J    = 2'b10,
        ICLASS_RSVD = 2'b11
    } iclass_e;

    // Logical immediates zero-extend, LUI shifts into the upper half, the rest sign-extend.
    function automatic logic [31:0] extend_imm(input logic [5:0] op, input logic [15:0] imm);
        logic [31:0] ext;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: ext = {16'h0000, imm};
            OP_LUI:                   ext = {imm, 16'h0000};
            default:                  ext = {{16{imm[15]}}, imm};
        endcase
        return ext;
    endfunction

    function automatic iclass_e classify(input logic [5:0] op);
        iclass_e cls;
        case (op)
            OP_SPECIAL:  cls = ICLASS_R;
            OP_J, OP_JAL: cls = ICLASS_J;
            default:     cls = ICLASS_I;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational field split, immediate extension and format classification
// of one instruction word; all outputs are forced to zero when not valid.
module inst_field_decode
    import inst_split_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] target,
    output logic [31:0] imm_ext,
    output logic [1:0]  iclass
);

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        opcode  = '0;
        rs      = '0;
        rt      = '0;
        rd      = '0;
        shamt   = '0;
        funct   = '0;
        imm16   = '0;
        target  = '0;
        imm_ext = '0;
        iclass  = '0;
        if (valid) begin
            opcode  = inst[31:26];
            rs      = inst[25:21];
            rt      = inst[20:16];
            rd      = inst[15:11];
            shamt   = inst[10:6];
            funct   = inst[5:0];
            imm16   = inst[15:0];
            target  = inst[25:0];
            imm_ext = extend_imm(inst[31:26], inst[15:0]);
            iclass  = classify(inst[31:26]);
        end
    end

endmodule

// File: rtl/inst_split_queue.sv
// Circular instruction queue of DEPTH words whose head entry is presented
// already split into fields, extended immediate and instruction class.
module inst_split_queue
    import inst_split_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      imm16,
    output logic [25:0]      target,
    output logic [31:0]      imm_ext,
    output logic [1:0]       iclass,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    logic [31:0]      head;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; out_valid masks stale contents at the decoder.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_inst;
    end

    assign head = mem[rd_ptr];

    inst_field_decode u_decode (
        .valid   (out_valid),
        .inst    (head),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm16   (imm16),
        .target  (target),
        .imm_ext (imm_ext),
        .iclass  (iclass)
    );

endmodule
